frame_sequencer: RTL and testbench

//  Scans a rectangular stonyman pixel window, one capture per pixel. For each pixel it presents
//  the row/col address, waits a settle time, then pulses adc_capture_start to the ADC controller.
//  adc_capture_done advances it to the next pixel. Sits between the MSS register bank and the ADC controller.

---
 rtl/frame_sequencer_if.sv | 44 ++++
 rtl/frame_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_frame_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sequencer_if.sv
// Handshake bundle between the register bank, the frame sequencer and the ADC controller.
// FRAME_SEQ_STRIDE_EN adds the row_stride/col_stride configuration inputs.
interface frame_sequencer_if #(
    parameter int ADDR_BITS   = 7,
    parameter int SETTLE_BITS = 8
);
    logic                     frame_start;
    logic                     frame_abort;
    logic [ADDR_BITS-1:0]     row_start;
    logic [ADDR_BITS-1:0]     row_end;
    logic [ADDR_BITS-1:0]     col_start;
    logic [ADDR_BITS-1:0]     col_end;
    logic [SETTLE_BITS-1:0]   settle_counts;
`ifdef FRAME_SEQ_STRIDE_EN
    logic [ADDR_BITS-1:0]     row_stride;
    logic [ADDR_BITS-1:0]     col_stride;
`endif
    logic                     adc_capture_done;
    logic                     adc_capture_start;
    logic [ADDR_BITS-1:0]     pix_row;
    logic [ADDR_BITS-1:0]     pix_col;
    logic                     busy;
    logic                     frame_done;
    logic                     frame_err;
    logic [2*ADDR_BITS-1:0]   pixel_count;

    modport slave (
`ifdef FRAME_SEQ_STRIDE_EN
        input  row_stride, col_stride,
`endif
        input  frame_start, frame_abort, row_start, row_end, col_start, col_end,
        input  settle_counts, adc_capture_done,
        output adc_capture_start, pix_row, pix_col, busy, frame_done, frame_err, pixel_count
    );

    modport master (
`ifdef FRAME_SEQ_STRIDE_EN
        output row_stride, col_stride,
`endif
        output frame_start, frame_abort, row_start, row_end, col_start, col_end,
        output settle_counts, adc_capture_done,
        input  adc_capture_start, pix_row, pix_col, busy, frame_done, frame_err, pixel_count
    );
endinterface

// File: rtl/frame_sequencer.sv
// Raster-scans a row/col pixel window, issuing one ADC capture per pixel after a settle delay.
// FRAME_SEQ_STRIDE_EN adds latched row/col strides; otherwise both strides are fixed at 1.
//
// state     | meaning
// IDLE      | waiting for frame_start; window/settle latched on accept
// LOAD      | validate window, present first pixel address
// SETTLE    | address settling, timer counts up to max(settle,1)-1
// START     | issue one adc_capture_start pulse
// WAIT_DONE | wait for adc_capture_done or timeout
// ADVANCE   | step column, wrap to next row, or finish
// DRAIN     | aborted with a capture in flight; wait for its done or timeout
// DONE      | one-cycle frame_done, then IDLE
module frame_sequencer #(
    parameter int ADDR_BITS   = 7,
    parameter int SETTLE_BITS = 8,
    parameter int TIMEOUT     = 1023
) (
    input  logic             clk,
    input  logic             reset,
    frame_sequencer_if.slave bus
);
    localparam int TIMEOUT_BITS = $clog2(TIMEOUT + 1);
    localparam int TIMER_BITS   = (TIMEOUT_BITS > SETTLE_BITS) ? TIMEOUT_BITS : SETTLE_BITS;
    localparam int COUNT_BITS   = 2 * ADDR_BITS;
    localparam logic [TIMER_BITS-1:0] TIMEOUT_LAST = TIMER_BITS'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_START,
        S_WAIT_DONE,
        S_ADVANCE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state;
    logic [ADDR_BITS-1:0]   row_start_q;
    logic [ADDR_BITS-1:0]   row_end_q;
    logic [ADDR_BITS-1:0]   col_start_q;
    logic [ADDR_BITS-1:0]   col_end_q;
    logic [ADDR_BITS-1:0]   row_stride;
    logic [ADDR_BITS-1:0]   col_stride;
    logic [SETTLE_BITS-1:0] settle_q;
    logic [TIMER_BITS-1:0]  timer;
    logic [ADDR_BITS-1:0]   pix_row_q;
    logic [ADDR_BITS-1:0]   pix_col_q;
    logic [COUNT_BITS-1:0]  pixel_count_q;
    logic                   adc_start_q;
    logic                   busy_q;
    logic                   frame_done_q;
    logic                   frame_err_q;

    logic [ADDR_BITS:0]     col_nxt;
    logic [ADDR_BITS:0]     row_nxt;
    logic [TIMER_BITS-1:0]  settle_last;
    logic                   window_bad;
    logic                   timeout_hit;
    logic                   accept;

    // One extra bit so a step past the top of the address space ends the row/frame instead of wrapping.
    assign col_nxt     = {1'b0, pix_col_q} + {1'b0, col_stride};
    assign row_nxt     = {1'b0, pix_row_q} + {1'b0, row_stride};
    assign settle_last = TIMER_BITS'(settle_q) - TIMER_BITS'(1);
    assign window_bad  = (row_start_q > row_end_q) || (col_start_q > col_end_q);
    assign timeout_hit = (timer == TIMEOUT_LAST);
    assign accept      = bus.frame_start && !bus.frame_abort;

`ifdef FRAME_SEQ_STRIDE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_stride <= ADDR_BITS'(1);
            col_stride <= ADDR_BITS'(1);
        end else if (state == S_IDLE && accept) begin
            row_stride <= (bus.row_stride == '0) ? ADDR_BITS'(1) : bus.row_stride;
            col_stride <= (bus.col_stride == '0) ? ADDR_BITS'(1) : bus.col_stride;
        end
    end
`else
    assign row_stride = ADDR_BITS'(1);
    assign col_stride = ADDR_BITS'(1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            row_start_q   <= '0;
            row_end_q     <= '0;
            col_start_q   <= '0;
            col_end_q     <= '0;
            settle_q      <= SETTLE_BITS'(1);
            timer         <= '0;
            pix_row_q     <= '0;
            pix_col_q     <= '0;
            pixel_count_q <= '0;
            adc_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            adc_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        row_start_q   <= bus.row_start;
                        row_end_q     <= bus.row_end;
                        col_start_q   <= bus.col_start;
                        col_end_q     <= bus.col_end;
                        settle_q      <= (bus.settle_counts == '0) ? SETTLE_BITS'(1) : bus.settle_counts;
                        pixel_count_q <= '0;
                        frame_err_q   <= 1'b0;
                        busy_q        <= 1'b1;
                        state         <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.frame_abort || window_bad) begin
                        frame_err_q  <= 1'b1;
                        frame_done_q <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        pix_row_q <= row_start_q;
                        pix_col_q <= col_start_q;
                        timer     <= '0;
                        state     <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (bus.frame_abort) begin
                        frame_err_q  <= 1'b1;
                        frame_done_q <= 1'b1;
                        state        <= S_DONE;
                    end else if (timer == settle_last) begin
                        state <= S_START;
                    end else begin
                        timer <= timer + TIMER_BITS'(1);
                    end
                end
                S_START: begin
                    // The pulse goes out even on abort, so the ADC's done must be drained.
                    adc_start_q <= 1'b1;
                    timer       <= '0;
                    if (bus.frame_abort) begin
                        frame_err_q <= 1'b1;
                        state       <= S_DRAIN;
                    end else begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.frame_abort) begin
                        frame_err_q <= 1'b1;
                        timer       <= '0;
                        if (bus.adc_capture_done) begin
                            frame_done_q <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else if (bus.adc_capture_done) begin
                        pixel_count_q <= pixel_count_q + COUNT_BITS'(1);
                        state         <= S_ADVANCE;
                    end else if (timeout_hit) begin
                        frame_err_q  <= 1'b1;
                        frame_done_q <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        timer <= timer + TIMER_BITS'(1);
                    end
                end
                S_ADVANCE: begin
                    timer <= '0;
                    if (bus.frame_abort) begin
                        frame_err_q  <= 1'b1;
                        frame_done_q <= 1'b1;
                        state        <= S_DONE;
                    end else if (col_nxt <= {1'b0, col_end_q}) begin
                        pix_col_q <= col_nxt[ADDR_BITS-1:0];
                        state     <= S_SETTLE;
                    end else begin
                        pix_col_q <= col_start_q;
                        if (row_nxt > {1'b0, row_end_q}) begin
                            frame_done_q <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            pix_row_q <= row_nxt[ADDR_BITS-1:0];
                            state     <= S_SETTLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.adc_capture_done || timeout_hit) begin
                        frame_done_q <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        timer <= timer + TIMER_BITS'(1);
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.adc_capture_start = adc_start_q;
    assign bus.pix_row           = pix_row_q;
    assign bus.pix_col           = pix_col_q;
    assign bus.busy              = busy_q;
    assign bus.frame_done        = frame_done_q;
    assign bus.frame_err         = frame_err_q;
    assign bus.pixel_count       = pixel_count_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: table of windows plus hand-built abort/timeout/reset sequences.
// t counts negedges after the cycle in which frame_start was driven.
module tb_frame_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   t = 0;
    int   resp_lat = 0;
    int   pend = 0;

    frame_sequencer_if #(.ADDR_BITS(7), .SETTLE_BITS(8)) bus ();

    frame_sequencer #(.ADDR_BITS(7), .SETTLE_BITS(8), .TIMEOUT(1023)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    // ADC model: done arrives resp_lat cycles after the start pulse; resp_lat 0 means never.
    initial begin
        bus.adc_capture_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.adc_capture_done = 1'b0;
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) bus.adc_capture_done = 1'b1;
            end
            if (bus.adc_capture_start && resp_lat > 0) pend = resp_lat;
        end
    end

    typedef struct {
        int rs, re, cs, ce, settle, lat;
        int exp_count, exp_err, exp_first, exp_done_t;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        t = t + 1;
        bus.frame_start = 1'b0;
        bus.frame_abort = 1'b0;
    endtask

    task automatic launch(input int rs, input int re, input int cs, input int ce,
                          input int settle, input int lat);
        @(negedge clk);
        bus.row_start     = 7'(rs);
        bus.row_end       = 7'(re);
        bus.col_start     = 7'(cs);
        bus.col_end       = 7'(ce);
        bus.settle_counts = 8'(settle);
        resp_lat          = lat;
        bus.frame_abort   = 1'b0;
        bus.frame_start   = 1'b1;
        t = 0;
    endtask

    task automatic run_until_done(input int budget, input int abort_at,
                                  output int nstart, output int start_t, output int done_t);
        nstart = 0;
        start_t = -1;
        done_t = -1;
        while (done_t < 0 && t < budget) begin
            tick();
            if (t == abort_at) bus.frame_abort = 1'b1;
            if (bus.adc_capture_start) begin
                nstart++;
                if (start_t < 0) start_t = t;
            end
            if (bus.frame_done) done_t = t;
        end
    endtask

    initial begin
        int k, first_t, done_t, start_t, nstart, w, busy_cnt, done_cnt;

        bus.frame_start   = 1'b0;
        bus.frame_abort   = 1'b0;
        bus.row_start     = '0;
        bus.row_end       = '0;
        bus.col_start     = '0;
        bus.col_end       = '0;
        bus.settle_counts = '0;
`ifdef FRAME_SEQ_STRIDE_EN
        bus.row_stride = 7'd1;
        bus.col_stride = 7'd1;
`endif
        //          rs   re   cs   ce  set lat  cnt err first done_t
        vecs[0] = '{2,   3,   5,   6,   4, 10,  4,  0,  7,   70};
        vecs[1] = '{7,   7,   9,   9,   0,  3,  1,  0,  4,    9};
        vecs[2] = '{10,  4,   0,   1,   2,  5,  0,  1,  0,    2};
        vecs[3] = '{0,   0,   0,   3,   1,  1,  4,  0,  4,   22};
        vecs[4] = '{1,   1,   9,   8,   3,  5,  0,  1,  0,    2};
        vecs[5] = '{126, 127, 127, 127, 255, 2, 2,  0,  258, 522};

        repeat (2) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        check("rst_frame_err", int'(bus.frame_err), 0);
        check("rst_adc_start", int'(bus.adc_capture_start), 0);
        check("rst_pix_row", int'(bus.pix_row), 0);
        check("rst_pix_col", int'(bus.pix_col), 0);
        check("rst_pixel_count", int'(bus.pixel_count), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].rs, vecs[i].re, vecs[i].cs, vecs[i].ce, vecs[i].settle, vecs[i].lat);
            k = 0;
            first_t = -1;
            done_t = -1;
            w = vecs[i].ce - vecs[i].cs + 1;
            while (done_t < 0 && t < 3000) begin
                tick();
                if (t == 1) begin
                    bus.row_start     = 7'd0;
                    bus.row_end       = 7'd127;
                    bus.col_start     = 7'd0;
                    bus.col_end       = 7'd127;
                    bus.settle_counts = 8'd0;
                end
                if (bus.adc_capture_start) begin
                    if (first_t < 0) first_t = t;
                    if (k < vecs[i].exp_count) begin
                        check($sformatf("v%0d_row%0d", i, k), int'(bus.pix_row), vecs[i].rs + k / w);
                        check($sformatf("v%0d_col%0d", i, k), int'(bus.pix_col), vecs[i].cs + k % w);
                    end
                    k++;
                    if (k == 1 && vecs[i].exp_count > 1) bus.frame_start = 1'b1;
                end
                if (bus.frame_done) begin
                    done_t = t;
                    check($sformatf("v%0d_busy_at_done", i), int'(bus.busy), 1);
                end
            end
            check($sformatf("v%0d_done_t", i), done_t, vecs[i].exp_done_t);
            check($sformatf("v%0d_captures", i), k, vecs[i].exp_count);
            check($sformatf("v%0d_pixel_count", i), int'(bus.pixel_count), vecs[i].exp_count);
            check($sformatf("v%0d_frame_err", i), int'(bus.frame_err), vecs[i].exp_err);
            if (vecs[i].exp_first > 0)
                check($sformatf("v%0d_first_start", i), first_t, vecs[i].exp_first);
            if (done_t < 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            tick();
            check($sformatf("v%0d_idle_busy", i), int'(bus.busy), 0);
            check($sformatf("v%0d_idle_done", i), int'(bus.frame_done), 0);
        end

        // Abort while waiting for done; the ADC's done lands 6 cycles later.
        launch(0, 1, 0, 1, 1, 8);
        run_until_done(200, 6, nstart, start_t, done_t);
        check("abort_wait_starts", nstart, 1);
        check("abort_wait_start_t", start_t, 4);
        check("abort_wait_done_t", done_t, 13);
        check("abort_wait_err", int'(bus.frame_err), 1);
        check("abort_wait_count", int'(bus.pixel_count), 0);
        tick();
        check("abort_wait_idle", int'(bus.busy), 0);

        // ADC never answers.
        launch(0, 0, 0, 0, 1, 0);
        run_until_done(1200, -1, nstart, start_t, done_t);
        check("timeout_starts", nstart, 1);
        check("timeout_gap", done_t - start_t, 1023);
        check("timeout_err", int'(bus.frame_err), 1);
        check("timeout_count", int'(bus.pixel_count), 0);

        // Abort on the START cycle: pulse still goes out, then drain.
        launch(0, 1, 0, 1, 1, 2);
        run_until_done(200, 3, nstart, start_t, done_t);
        check("abort_start_starts", nstart, 1);
        check("abort_start_start_t", start_t, 4);
        check("abort_start_done_t", done_t, 7);
        check("abort_start_err", int'(bus.frame_err), 1);
        check("abort_start_count", int'(bus.pixel_count), 0);

        // Abort during a long settle.
        launch(0, 3, 0, 3, 50, 5);
        run_until_done(200, 10, nstart, start_t, done_t);
        check("abort_settle_starts", nstart, 0);
        check("abort_settle_done_t", done_t, 11);
        check("abort_settle_err", int'(bus.frame_err), 1);

        // Start and abort together in IDLE: not accepted, frame_err stays sticky.
        @(negedge clk);
        bus.frame_start = 1'b1;
        bus.frame_abort = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.busy) busy_cnt++;
            if (bus.frame_done) done_cnt++;
        end
        check("start_abort_busy", busy_cnt, 0);
        check("start_abort_done", done_cnt, 0);
        check("start_abort_err_sticky", int'(bus.frame_err), 1);

        // Reset in the middle of a frame.
        launch(1, 2, 1, 2, 3, 20);
        while (t < 8) tick();
        check("midrst_busy_before", int'(bus.busy), 1);
        reset = 1'b1;
        #1;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_pix_row", int'(bus.pix_row), 0);
        check("midrst_pix_col", int'(bus.pix_col), 0);
        check("midrst_adc_start", int'(bus.adc_capture_start), 0);
        tick();
        tick();
        reset = 1'b0;
        done_cnt = 0;
        nstart = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.frame_done) done_cnt++;
            if (bus.adc_capture_start) nstart++;
        end
        check("midrst_no_done", done_cnt, 0);
        check("midrst_no_start", nstart, 0);
        check("midrst_busy_after", int'(bus.busy), 0);

`ifdef FRAME_SEQ_STRIDE_EN
        bus.row_stride = 7'd2;
        bus.col_stride = 7'd2;
        launch(0, 4, 0, 4, 1, 2);
        k = 0;
        done_t = -1;
        while (done_t < 0 && t < 1000) begin
            tick();
            if (bus.adc_capture_start) begin
                check($sformatf("stride_row%0d", k), int'(bus.pix_row), 2 * (k / 3));
                check($sformatf("stride_col%0d", k), int'(bus.pix_col), 2 * (k % 3));
                k++;
                if (k == 3) bus.frame_start = 1'b1;
            end
            if (bus.frame_done) done_t = t;
        end
        check("stride_captures", k, 9);
        check("stride_count", int'(bus.pixel_count), 9);
        check("stride_err", int'(bus.frame_err), 0);
        bus.row_stride = 7'd1;
        bus.col_stride = 7'd1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
